// File: rtl/hazard_forward_unit.sv
// Operand bypass select and pipeline hazard control for NUM_SRC sources.
// Handles load-use bubbles and a freeze while a load waits in MEM.
module hazard_forward_unit #(
   parameter int RA_W     = 4,
   parameter int NUM_SRC  = 2,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ifid_valid,
   input  logic [NUM_SRC*RA_W-1:0]   ifid_rs,
   input  logic [NUM_SRC-1:0]        ifid_rs_used,
   input  logic [NUM_SRC*RA_W-1:0]   idex_rs,
   input  logic [RA_W-1:0]           idex_rd,
   input  logic                      idex_reg_write,
   input  logic                      idex_mem_to_reg,
   input  logic [RA_W-1:0]           exmem_rd,
   input  logic                      exmem_reg_write,
   input  logic                      exmem_mem_to_reg,
   input  logic                      mem_ready,
   input  logic [RA_W-1:0]           memwb_rd,
   input  logic                      memwb_reg_write,
   output logic [2*NUM_SRC-1:0]      forward_sel,
   output logic                      stall_if,
   output logic                      stall_id,
   output logic                      bubble_ex,
   output logic                      stall_mem,
   output logic                      mem_timeout,
   output logic [CNT_W-1:0]          stall_cycles
);

   localparam int WC_W = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t            state;
   state_t            state_nx;
   logic              freeze;
   logic              load_use;
   logic              hazard;
   logic              ex_alu;
   logic              wb_ok;
   logic              id_load;
   logic              mem_miss;
   logic [2*NUM_SRC-1:0] fwd;
   logic [WC_W-1:0]   wait_cnt;

   function automatic logic rd_ok(input logic [RA_W-1:0] rd);
      return (ZERO_REG == 0) || (rd != '0);
   endfunction

   assign ex_alu   = exmem_reg_write && !exmem_mem_to_reg && rd_ok(exmem_rd);
   assign wb_ok    = memwb_reg_write && rd_ok(memwb_rd);
   assign id_load  = ifid_valid && idex_reg_write && idex_mem_to_reg
                     && rd_ok(idex_rd);
   assign mem_miss = exmem_reg_write && exmem_mem_to_reg && !mem_ready;

   always_comb begin
      fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_alu && exmem_rd == idex_rs[i*RA_W +: RA_W])
            fwd[2*i +: 2] = 2'b10;
         else if (wb_ok && memwb_rd == idex_rs[i*RA_W +: RA_W])
            fwd[2*i +: 2] = 2'b01;
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ifid_rs_used[i] && idex_rd == ifid_rs[i*RA_W +: RA_W])
            hazard = id_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      freeze   = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_miss) begin
               state_nx = MEM_WAIT;
               freeze   = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) state_nx = RUN;
            else           freeze   = 1'b1;
         end
         default: state_nx = RUN;
      endcase
   end

   // The MEM freeze wins over a load-use bubble in the same cycle.
   always_comb begin
      load_use    = (state == RUN) && !freeze && hazard;
      forward_sel = rst ? '0 : fwd;
      stall_if    = !rst && (freeze || load_use);
      stall_id    = !rst && freeze;
      stall_mem   = !rst && freeze;
      bubble_ex   = !rst && load_use;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (freeze) begin
         if (wait_cnt != WC_MAX) wait_cnt <= wait_cnt + 1'b1;
         if (int'(wait_cnt) + 1 >= TIMEOUT) mem_timeout <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall_if && stall_cycles != '1)
         stall_cycles <= stall_cycles + 1'b1;
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Random and directed checks of hazard_forward_unit against a cycle model.
// Two instances cover NUM_SRC/ZERO_REG/TIMEOUT/CNT_W variants.
module tb_hazard_forward_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       ifid_valid, idex_reg_write, idex_mem_to_reg;
   logic       exmem_reg_write, exmem_mem_to_reg, mem_ready;
   logic       memwb_reg_write;
   logic [3:0] idex_rd, exmem_rd, memwb_rd;
   logic [3:0] ifrs [3];
   logic [3:0] idrs [3];
   logic       used [3];

   logic [7:0]  ifid_rs0, idex_rs0;
   logic [1:0]  used0;
   logic [11:0] ifid_rs1, idex_rs1;
   logic [2:0]  used1;

   assign ifid_rs0 = {ifrs[1], ifrs[0]};
   assign idex_rs0 = {idrs[1], idrs[0]};
   assign used0    = {used[1], used[0]};
   assign ifid_rs1 = {ifrs[2], ifrs[1], ifrs[0]};
   assign idex_rs1 = {idrs[2], idrs[1], idrs[0]};
   assign used1    = {used[2], used[1], used[0]};

   logic [3:0]  fs0;
   logic [5:0]  fs1;
   logic        sif0, sid0, bub0, smem0, to0;
   logic        sif1, sid1, bub1, smem1, to1;
   logic [3:0]  sc0;
   logic [15:0] sc1;

   hazard_forward_unit #(
      .RA_W(4), .NUM_SRC(2), .ZERO_REG(1), .CNT_W(4), .TIMEOUT(4)
   ) u0 (
      .clk(clk), .rst(rst), .ifid_valid(ifid_valid),
      .ifid_rs(ifid_rs0), .ifid_rs_used(used0), .idex_rs(idex_rs0),
      .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
      .idex_mem_to_reg(idex_mem_to_reg), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write),
      .exmem_mem_to_reg(exmem_mem_to_reg), .mem_ready(mem_ready),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .forward_sel(fs0), .stall_if(sif0), .stall_id(sid0),
      .bubble_ex(bub0), .stall_mem(smem0), .mem_timeout(to0),
      .stall_cycles(sc0)
   );

   hazard_forward_unit #(
      .RA_W(4), .NUM_SRC(3), .ZERO_REG(0), .CNT_W(16), .TIMEOUT(6)
   ) u1 (
      .clk(clk), .rst(rst), .ifid_valid(ifid_valid),
      .ifid_rs(ifid_rs1), .ifid_rs_used(used1), .idex_rs(idex_rs1),
      .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
      .idex_mem_to_reg(idex_mem_to_reg), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write),
      .exmem_mem_to_reg(exmem_mem_to_reg), .mem_ready(mem_ready),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .forward_sel(fs1), .stall_if(sif1), .stall_id(sid1),
      .bubble_ex(bub1), .stall_mem(smem1), .mem_timeout(to1),
      .stall_cycles(sc1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: per-instance configuration and state
   int NS [2] = '{2, 3};
   int ZR [2] = '{1, 0};
   int TO [2] = '{4, 6};
   int SCM[2] = '{15, 65535};
   bit m_wait [2];
   int m_cnt  [2];
   bit m_to   [2];
   int m_sc   [2];

   function automatic bit ok(int k, logic [3:0] rd);
      return ZR[k] == 0 || rd != 0;
   endfunction

   task automatic model(input int k, output logic [31:0] fs,
                        output logic [31:0] st, output bit frz,
                        output bit sif);
      bit haz, lu, miss;
      fs = 0;
      for (int i = 0; i < NS[k]; i++) begin
         int sel;
         sel = 0;
         if (exmem_reg_write && !exmem_mem_to_reg && ok(k, exmem_rd)
             && exmem_rd == idrs[i])
            sel = 2;
         else if (memwb_reg_write && ok(k, memwb_rd) && memwb_rd == idrs[i])
            sel = 1;
         fs = fs + (sel << (2 * i));
      end
      miss = exmem_reg_write && exmem_mem_to_reg && !mem_ready;
      frz  = m_wait[k] ? !mem_ready : miss;
      haz  = 0;
      for (int i = 0; i < NS[k]; i++)
         if (used[i] && ok(k, idex_rd) && idex_rd == ifrs[i]) haz = 1;
      haz = haz && ifid_valid && idex_reg_write && idex_mem_to_reg;
      lu  = !m_wait[k] && !frz && haz;
      sif = frz || lu;
      st  = {28'b0, sif, frz, lu, frz};
   endtask

   task automatic step();
      logic [31:0] fs [2];
      logic [31:0] st [2];
      bit frz [2];
      bit sif [2];
      #1;
      for (int k = 0; k < 2; k++) model(k, fs[k], st[k], frz[k], sif[k]);
      check("fwd0", 32'(fs0), fs[0]);
      check("fwd1", 32'(fs1), fs[1]);
      check("ctl0", 32'({sif0, sid0, bub0, smem0}), st[0]);
      check("ctl1", 32'({sif1, sid1, bub1, smem1}), st[1]);
      check("to0", 32'(to0), 32'(m_to[0]));
      check("to1", 32'(to1), 32'(m_to[1]));
      check("sc0", 32'(sc0), 32'(m_sc[0]));
      check("sc1", 32'(sc1), 32'(m_sc[1]));
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (sif[k] && m_sc[k] < SCM[k]) m_sc[k]++;
         if (frz[k]) begin
            m_cnt[k]++;
            if (m_cnt[k] >= TO[k]) m_to[k] = 1;
         end else begin
            m_cnt[k] = 0;
         end
         m_wait[k] = frz[k];
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst0", 32'({fs0, sif0, sid0, bub0, smem0, to0, sc0}), 32'd0);
      check("rst1", 32'({fs1, sif1, sid1, bub1, smem1, to1, sc1}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 0; m_cnt[k] = 0; m_to[k] = 0; m_sc[k] = 0;
      end
   endtask

   task automatic clr();
      ifid_valid = 0; idex_reg_write = 0; idex_mem_to_reg = 0;
      exmem_reg_write = 0; exmem_mem_to_reg = 0; mem_ready = 0;
      memwb_reg_write = 0;
      idex_rd = 0; exmem_rd = 0; memwb_rd = 0;
      for (int i = 0; i < 3; i++) begin
         ifrs[i] = 0; idrs[i] = 0; used[i] = 0;
      end
   endtask

   task automatic rnd();
      ifid_valid       = 1'($urandom_range(0, 1));
      idex_reg_write   = 1'($urandom_range(0, 1));
      idex_mem_to_reg  = 1'($urandom_range(0, 1));
      exmem_reg_write  = 1'($urandom_range(0, 1));
      exmem_mem_to_reg = 1'($urandom_range(0, 1));
      mem_ready        = 1'($urandom_range(0, 1));
      memwb_reg_write  = 1'($urandom_range(0, 1));
      idex_rd  = 4'($urandom_range(0, 3));
      exmem_rd = 4'($urandom_range(0, 3));
      memwb_rd = 4'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
         ifrs[i] = 4'($urandom_range(0, 3));
         idrs[i] = 4'($urandom_range(0, 3));
         used[i] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      clr();
      @(negedge clk);
      do_reset();

      exmem_reg_write = 1; exmem_rd = 3;
      for (int i = 0; i < 3; i++) idrs[i] = 3;
      step();
      check("alu_chain", 32'(fs0), 32'b1010);
      exmem_rd = 0; for (int i = 0; i < 3; i++) idrs[i] = 0;
      step();
      check("alu_r0", 32'(fs0), 32'b0000);
      check("alu_r0_nz", 32'(fs1), 32'b101010);

      clr(); exmem_reg_write = 1; exmem_rd = 5; memwb_reg_write = 1;
      memwb_rd = 5; idrs[0] = 5; mem_ready = 1;
      step();
      check("prio_ex", 32'(fs0), 32'b0010);
      exmem_mem_to_reg = 1;
      step();
      check("prio_load", 32'(fs0), 32'b0001);

      do_reset(); clr();
      ifid_valid = 1; idex_reg_write = 1; idex_mem_to_reg = 1;
      idex_rd = 7; ifrs[1] = 7; used[1] = 1;
      step();
      clr();
      step();
      check("lu_cnt", 32'(sc0), 32'd1);
      ifid_valid = 1; idex_reg_write = 1; idex_mem_to_reg = 1;
      idex_rd = 7; ifrs[1] = 7; used[1] = 0;
      step();
      check("lu_unused", 32'(sif0), 32'd0);

      do_reset(); clr();
      exmem_reg_write = 1; exmem_mem_to_reg = 1; exmem_rd = 4;
      repeat (3) step();
      mem_ready = 1;
      step();
      check("wait_cnt", 32'(sc0), 32'd3);

      do_reset(); clr();
      exmem_reg_write = 1; exmem_mem_to_reg = 1; exmem_rd = 4;
      repeat (6) step();
      check("timeout", 32'(to0), 32'd1);
      mem_ready = 1;
      step();
      check("timeout_sticky", 32'(to0), 32'd1);
      mem_ready = 0;
      repeat (2) step();
      do_reset();

      clr(); idrs[1] = 2; memwb_reg_write = 1; memwb_rd = 0; mem_ready = 1;
      step();
      check("zero_fwd3", 32'(fs1), 32'b010001);

      for (int n = 0; n < 900; n++) begin
         if (n % 70 == 69) do_reset();
         rnd();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
